muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide sequencer. It sits beside the single-cycle ALU in the execute stage.

---
 rtl/muldiv_seq_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_seq.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: widths, op encodings,
// FSM state encoding and the conditional-negate helpers used for sign fixup.
package muldiv_seq_pkg;

    localparam int ALU_DATA_LEN = 32;
    localparam int ALU_SEL_LEN  = 4;
    localparam int DATA_LEN     = ALU_DATA_LEN;
    localparam int CNT_LEN      = 5;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic [DATA_LEN-1:0] cneg(input logic [DATA_LEN-1:0] v, input logic en);
        return en ? (~v + {{(DATA_LEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*DATA_LEN-1:0] cneg_w(input logic [2*DATA_LEN-1:0] v, input logic en);
        return en ? (~v + {{(2*DATA_LEN-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer: a shift-add multiply step or a
// restoring-divide step on the {hi, lo} accumulator.
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  logic                  div_i,
    input  logic [2*DATA_LEN-1:0] acc_i,
    input  logic [DATA_LEN-1:0]   operand_i,
    output logic [2*DATA_LEN-1:0] acc_o
);

    logic [DATA_LEN:0] sum_s;
    logic [DATA_LEN:0] trial_s;

    // Divide: {rem, q} << 1 with trial subtract; multiply: conditional add then >> 1.
    always_comb begin
        sum_s   = {(DATA_LEN+1){1'b0}};
        trial_s = {(DATA_LEN+1){1'b0}};
        acc_o   = acc_i;
        if (div_i) begin
            // The shifted remainder needs 33 bits; bit 32 of the difference is the borrow.
            trial_s = acc_i[2*DATA_LEN-1:DATA_LEN-1] - {1'b0, operand_i};
            if (!trial_s[DATA_LEN]) begin
                acc_o = {trial_s[DATA_LEN-1:0], acc_i[DATA_LEN-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*DATA_LEN-2:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                sum_s = {1'b0, acc_i[2*DATA_LEN-1:DATA_LEN]} + {1'b0, operand_i};
            end else begin
                sum_s = {1'b0, acc_i[2*DATA_LEN-1:DATA_LEN]};
            end
            acc_o = {sum_s, acc_i[DATA_LEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (IDLE -> CALC -> FIX -> DONE), 34-cycle latency.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC (done in cycle 2).
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [DATA_LEN-1:0] src1,
    input  logic [DATA_LEN-1:0] src2,
    output logic                busy,
    output logic                stall,
    output logic                done,
    output logic [DATA_LEN-1:0] result
);

    md_state_e             state_q, state_d;
    md_op_e                op_q, op_d;
    logic [CNT_LEN-1:0]    cnt_q, cnt_d;
    logic [DATA_LEN-1:0]   opnd_q, opnd_d;
    logic [DATA_LEN-1:0]   raw_q, raw_d;
    logic [2*DATA_LEN-1:0] acc_q, acc_d;
    logic [DATA_LEN-1:0]   result_q, result_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  div0_q, div0_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    md_op_e                op_in_s;
    logic                  sgn1_s, sgn2_s, accept_s, early_s, ovf_fix_s;
    logic [DATA_LEN-1:0]   abs1_s, abs2_s, fix_res_s;
    logic [2*DATA_LEN-1:0] step_acc_s, prod_s;

    assign op_in_s  = md_op_e'(op);
    assign accept_s = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign sgn1_s   = (op_in_s inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & src1[DATA_LEN-1];
    assign sgn2_s   = (op_in_s inside {MD_MUL, MD_MULH, MD_DIV, MD_REM}) & src2[DATA_LEN-1];
    assign abs1_s   = cneg(src1, sgn1_s);
    assign abs2_s   = cneg(src2, sgn2_s);

`ifdef MULDIV_EARLY_OUT_EN
    logic ovf_in_s, ovf_q;
    assign ovf_in_s  = (op_in_s inside {MD_DIV, MD_REM})
                     & (src1 == {1'b1, {(DATA_LEN-1){1'b0}}})
                     & (src2 == {DATA_LEN{1'b1}});
    assign early_s   = op_in_s[2] & ((src2 == {DATA_LEN{1'b0}}) | ovf_in_s);
    assign ovf_fix_s = ovf_q;

    // Overflow flag for the early-out path, which never runs the divide loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept_s) begin
            ovf_q <= ovf_in_s;
        end else begin
            ovf_q <= ovf_q;
        end
    end
`else
    assign early_s   = 1'b0;
    assign ovf_fix_s = 1'b0;
`endif

    muldiv_step u_step (
        .div_i     (op_q[2]),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc_s)
    );

    // Sign fixup and output selection applied in FIX.
    always_comb begin
        prod_s    = cneg_w(acc_q, neg_res_q);
        fix_res_s = {DATA_LEN{1'b0}};
        case (op_q)
            MD_MUL:                       fix_res_s = prod_s[DATA_LEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res_s = prod_s[2*DATA_LEN-1:DATA_LEN];
            MD_DIV, MD_DIVU: begin
                if (div0_q) begin
                    fix_res_s = {DATA_LEN{1'b1}};
                end else if (ovf_fix_s) begin
                    fix_res_s = {1'b1, {(DATA_LEN-1){1'b0}}};
                end else begin
                    fix_res_s = cneg(acc_q[DATA_LEN-1:0], neg_res_q);
                end
            end
            MD_REM, MD_REMU: begin
                if (div0_q) begin
                    fix_res_s = raw_q;
                end else if (ovf_fix_s) begin
                    fix_res_s = {DATA_LEN{1'b0}};
                end else begin
                    fix_res_s = cneg(acc_q[2*DATA_LEN-1:DATA_LEN], neg_rem_q);
                end
            end
            default:                      fix_res_s = {DATA_LEN{1'b0}};
        endcase
    end

    // Next-state, operand capture, iteration and result update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        raw_d     = raw_q;
        acc_d     = acc_q;
        result_d  = result_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        if (accept_s) begin
            // The step operand is the divisor for divides and the multiplicand for multiplies.
            op_d      = op_in_s;
            cnt_d     = {CNT_LEN{1'b0}};
            opnd_d    = op_in_s[2] ? abs2_s : abs1_s;
            acc_d     = {{DATA_LEN{1'b0}}, (op_in_s[2] ? abs1_s : abs2_s)};
            raw_d     = src1;
            neg_res_d = sgn1_s ^ sgn2_s;
            neg_rem_d = sgn1_s;
            div0_d    = (src2 == {DATA_LEN{1'b0}});
        end else begin
            op_d = op_q;
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d = early_s ? ST_FIX : ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = step_acc_s;
                cnt_d = cnt_q + {{(CNT_LEN-1){1'b0}}, 1'b1};
                if (cnt_q == {CNT_LEN{1'b1}}) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FIX: begin
                result_d = fix_res_s;
                state_d  = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_CALC) | (state_d == ST_FIX);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= MD_MUL;
            cnt_q     <= {CNT_LEN{1'b0}};
            opnd_q    <= {DATA_LEN{1'b0}};
            raw_q     <= {DATA_LEN{1'b0}};
            acc_q     <= {(2*DATA_LEN){1'b0}};
            result_q  <= {DATA_LEN{1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            raw_q     <= raw_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign stall  = busy_q | (start & (state_q == ST_IDLE));
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected result and done cycle are queued at issue
// and checked when done pulses; a reference model covers random operations.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        busy, stall, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        cyc = 0;
    int        n_checks = 0;
    int        n_fail = 0;

    muldiv_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb_v;
        logic               ovf;
        sa   = a;
        sb_v = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb_v));
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb_v));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = o[2] && ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_EARLY_OUT_EN
        return special ? 2 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    // Drive a one-cycle start, queue the expectation; returns #1 into cycle 1.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit idle_chk);
        sb_entry_t e;
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        e.res = exp;
        e.cyc = cyc + lat;
        sb.push_back(e);
        if (idle_chk) begin
            @(negedge clk);
            check("stall_on_accept", stall, 1'b1);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Scoreboard monitor: every done must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", busy, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d outstanding", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        #3;
        check("rst_result", result, 32'd0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_stall", stall, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // MUL 7 x -3 with stall/busy window tracking
        issue(MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
        bad = 0;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (!stall || done) bad++;
        end
        check("stall_window", bad, 0);
        @(negedge clk);
        check("done_c34", done, 1'b1);
        check("stall_c34", stall, 1'b0);
        check("busy_c34", busy, 1'b0);
        drain(10);

        issue(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b1); drain(60);
        issue(MD_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b1); drain(60);
        issue(MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1); drain(60);
        issue(MD_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1); drain(60);
        issue(MD_DIVU,  32'd100, 32'd7, 32'd14, 34, 1'b1); drain(60);
        issue(MD_REMU,  32'd100, 32'd7, 32'd2, 34, 1'b1); drain(60);

        // Divide by zero and signed overflow
        issue(MD_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, lat_of(3'd4, 32'd5, 32'd0), 1'b1); drain(60);
        issue(MD_REM, 32'd5, 32'd0, 32'd5, lat_of(3'd6, 32'd5, 32'd0), 1'b1); drain(60);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
              lat_of(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 1'b1); drain(60);
        issue(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
              lat_of(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 1'b1); drain(60);

        // start pulsed during CALC is ignored
        issue(MD_DIVU, 32'd1000, 32'd9, 32'd111, 34, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        start = 1'b1; op = MD_MUL; src1 = 32'd5; src2 = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(60);
        repeat (40) @(posedge clk);
        check("idle_after_ignored_start", busy, 1'b0);

        // start held in the DONE cycle is accepted back-to-back
        issue(MD_MUL, 32'd6, 32'd7, 32'd42, 34, 1'b1);
        repeat (32) @(posedge clk);
        issue(MD_REMU, 32'd100, 32'd7, 32'd2, 34, 1'b0);
        drain(80);

        // Random operations against the reference model
        for (int k = 0; k < 10; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb, ref_md(ro, ra, rb), lat_of(ro, ra, rb), 1'b1);
            drain(60);
        end

        // Reset in cycle 15 of a DIV aborts it with no done
        issue(MD_DIV, 32'd1000, 32'd3, 32'd333, 34, 1'b1);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_result", result, 32'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_stall", stall, 1'b0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(MD_MUL, 32'd3, 32'd4, 32'd12, 34, 1'b1);
        drain(60);
        repeat (5) @(posedge clk);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
